// File: rtl/nearest_hit_scheduler.sv
// Nearest-hit scheduler: runs a min tree over BATCHES batches per ray and returns the nearest {batch,slot} and distance on valid/ready.
// Result 1 cycle after the last accept (2 with NEAREST_HIT_PIPE_EN, which registers the tree output); batch_ready is low while a result waits.

module nhs_min_tree #(
  parameter int WIDTH  = 3,
  parameter int LENGTH = 10
) (
  input  logic [(2**WIDTH)*LENGTH-1:0] i_bus,
  output logic [WIDTH-1:0]             o_slot,
  output logic [LENGTH-1:0]            o_dist
);
  localparam int N = 2**WIDTH;

  logic [LENGTH-1:0] w_d [N];
  logic [WIDTH-1:0]  w_s [N];

  // Pairwise reduction in place; the lower slot survives unless the upper one is strictly smaller.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_d[k] = i_bus[k*LENGTH +: LENGTH];
      w_s[k] = WIDTH'(k);
    end
    for (int l = 0; l < WIDTH; l++) begin
      for (int k = 0; k < N; k += (2 << l)) begin
        if (w_d[k + (1 << l)] < w_d[k]) begin
          w_d[k] = w_d[k + (1 << l)];
          w_s[k] = w_s[k + (1 << l)];
        end
      end
    end
    o_slot = w_s[0];
    o_dist = w_d[0];
  end
endmodule

module nearest_hit_scheduler #(
  parameter int WIDTH   = 3,
  parameter int LENGTH  = 10,
  parameter int BATCHES = 4,
  parameter int BATCH_W = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          batch_valid,
  output logic                          batch_ready,
  input  logic [(2**WIDTH)*LENGTH-1:0]  batch_bus,
  output logic                          hit_valid,
  input  logic                          hit_ready,
  output logic [BATCH_W+WIDTH-1:0]      hit_index,
  output logic [LENGTH-1:0]             hit_dist,
  output logic                          hit_found,
  output logic                          busy
);
  localparam logic [LENGTH-1:0]  MISS = '1;
  localparam logic [BATCH_W-1:0] LAST = BATCH_W'(BATCHES - 1);

`ifdef NEAREST_HIT_PIPE_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_COLLECT = 2'd1, S_RESULT = 2'd2, S_CMP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_COLLECT = 2'd1, S_RESULT = 2'd2} state_t;
`endif

  state_t                     r_state, w_state_nxt;
  logic [LENGTH-1:0]          r_min, w_min_nxt;
  logic [BATCH_W+WIDTH-1:0]   r_idx, w_idx_nxt;
  logic [BATCH_W-1:0]         r_cnt, w_cnt_nxt;
  logic [BATCH_W+WIDTH-1:0]   r_hit_index, w_hit_index_nxt;
  logic [LENGTH-1:0]          r_hit_dist, w_hit_dist_nxt;
  logic                       r_hit_found, w_hit_found_nxt;

  logic [WIDTH-1:0]           w_tree_slot;
  logic [LENGTH-1:0]          w_tree_dist;
  logic                       w_accept;
  logic [LENGTH-1:0]          w_cand_dist;
  logic [BATCH_W+WIDTH-1:0]   w_cand_idx;
  logic [LENGTH-1:0]          w_merge_min;
  logic [BATCH_W+WIDTH-1:0]   w_merge_idx;

  nhs_min_tree #(
    .WIDTH  (WIDTH),
    .LENGTH (LENGTH)
  ) u_tree (
    .i_bus  (batch_bus),
    .o_slot (w_tree_slot),
    .o_dist (w_tree_dist)
  );

  assign batch_ready = (r_state == S_COLLECT);
  assign hit_valid   = (r_state == S_RESULT);
  assign busy        = (r_state != S_IDLE);
  assign hit_index   = r_hit_index;
  assign hit_dist    = r_hit_dist;
  assign hit_found   = r_hit_found;
  assign w_accept    = batch_valid && (r_state == S_COLLECT);

`ifdef NEAREST_HIT_PIPE_EN
  logic [WIDTH-1:0]   r_stg_slot, w_stg_slot_nxt;
  logic [LENGTH-1:0]  r_stg_dist, w_stg_dist_nxt;
  logic [BATCH_W-1:0] r_stg_cnt, w_stg_cnt_nxt;
  logic               r_stg_last, w_stg_last_nxt;

  assign w_cand_dist = r_stg_dist;
  assign w_cand_idx  = {r_stg_cnt, r_stg_slot};
`else
  assign w_cand_dist = w_tree_dist;
  assign w_cand_idx  = {r_cnt, w_tree_slot};
`endif

  // Strict compare: on equal distance the earlier batch keeps the win.
  assign w_merge_min = (w_cand_dist < r_min) ? w_cand_dist : r_min;
  assign w_merge_idx = (w_cand_dist < r_min) ? w_cand_idx  : r_idx;

  always_comb begin
    w_state_nxt     = r_state;
    w_min_nxt       = r_min;
    w_idx_nxt       = r_idx;
    w_cnt_nxt       = r_cnt;
    w_hit_index_nxt = r_hit_index;
    w_hit_dist_nxt  = r_hit_dist;
    w_hit_found_nxt = r_hit_found;
`ifdef NEAREST_HIT_PIPE_EN
    w_stg_slot_nxt  = r_stg_slot;
    w_stg_dist_nxt  = r_stg_dist;
    w_stg_cnt_nxt   = r_stg_cnt;
    w_stg_last_nxt  = r_stg_last;
`endif
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_min_nxt   = MISS;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (w_accept) begin
            w_cnt_nxt = r_cnt + BATCH_W'(1);
`ifdef NEAREST_HIT_PIPE_EN
            w_stg_slot_nxt = w_tree_slot;
            w_stg_dist_nxt = w_tree_dist;
            w_stg_cnt_nxt  = r_cnt;
            w_stg_last_nxt = (r_cnt == LAST);
            w_state_nxt    = S_CMP;
`else
            w_min_nxt = w_merge_min;
            w_idx_nxt = w_merge_idx;
            if (r_cnt == LAST) begin
              w_hit_index_nxt = w_merge_idx;
              w_hit_dist_nxt  = w_merge_min;
              w_hit_found_nxt = (w_merge_min != MISS);
              w_state_nxt     = S_RESULT;
            end
`endif
          end
        end
`ifdef NEAREST_HIT_PIPE_EN
        S_CMP: begin
          w_min_nxt = w_merge_min;
          w_idx_nxt = w_merge_idx;
          if (r_stg_last) begin
            w_hit_index_nxt = w_merge_idx;
            w_hit_dist_nxt  = w_merge_min;
            w_hit_found_nxt = (w_merge_min != MISS);
            w_state_nxt     = S_RESULT;
          end else begin
            w_state_nxt = S_COLLECT;
          end
        end
`endif
        S_RESULT: begin
          if (hit_ready) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_min       <= MISS;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_hit_index <= '0;
      r_hit_dist  <= MISS;
      r_hit_found <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_min       <= w_min_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hit_index <= w_hit_index_nxt;
      r_hit_dist  <= w_hit_dist_nxt;
      r_hit_found <= w_hit_found_nxt;
    end
  end

`ifdef NEAREST_HIT_PIPE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg_slot <= '0;
      r_stg_dist <= MISS;
      r_stg_cnt  <= '0;
      r_stg_last <= 1'b0;
    end else begin
      r_stg_slot <= w_stg_slot_nxt;
      r_stg_dist <= w_stg_dist_nxt;
      r_stg_cnt  <= w_stg_cnt_nxt;
      r_stg_last <= w_stg_last_nxt;
    end
  end
`endif
endmodule

// File: tb/tb_nearest_hit_scheduler.sv
// Bench for nearest_hit_scheduler: directed scenarios plus randomized rays against a scan-order reference.
module tb_nearest_hit_scheduler;
  localparam int W  = 3;
  localparam int L  = 10;
  localparam int B  = 4;
  localparam int BW = 2;
  localparam int N  = 8;
  localparam logic [L-1:0] MISS = '1;
`ifdef NEAREST_HIT_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n, start, abort, batch_valid, batch_ready, hit_valid, hit_ready, hit_found, busy;
  logic [N*L-1:0]  batch_bus;
  logic [BW+W-1:0] hit_index;
  logic [L-1:0]    hit_dist;

  logic [L-1:0] g_d [B][N];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  nearest_hit_scheduler #(.WIDTH(W), .LENGTH(L), .BATCHES(B), .BATCH_W(BW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .batch_valid(batch_valid), .batch_ready(batch_ready), .batch_bus(batch_bus),
    .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_index(hit_index),
    .hit_dist(hit_dist), .hit_found(hit_found), .busy(busy)
  );

  // Reference: scan batches then slots in order, keep first strictly-smaller distance.
  function automatic void ref_nearest(output logic [BW+W-1:0] idx, output logic [L-1:0] d);
    d = MISS;
    idx = '0;
    for (int b = 0; b < B; b++)
      for (int k = 0; k < N; k++)
        if (g_d[b][k] < d) begin
          d = g_d[b][k];
          idx = (BW+W)'(b*N + k);
        end
  endfunction

  task automatic fill(input logic [L-1:0] v);
    for (int b = 0; b < B; b++)
      for (int k = 0; k < N; k++) g_d[b][k] = v;
  endtask

  task automatic load_scn1();
    fill(MISS);
    g_d[0][5] = 10'd300;
    g_d[1][2] = 10'd100;
    g_d[2][7] = 10'd100;
  endtask

  task automatic feed_ray(input int nb, input int max_gap, output int lat, output bit ok);
    ok = 1'b1;
    lat = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int b = 0; b < nb; b++) begin
      int gap;
      int wt;
      gap = $urandom_range(max_gap, 0);
      repeat (gap) @(negedge clk);
      for (int k = 0; k < N; k++) batch_bus[k*L +: L] = g_d[b][k];
      batch_valid = 1'b1;
      wt = 0;
      while (!batch_ready && wt < 20) begin @(negedge clk); wt++; end
      if (!batch_ready) ok = 1'b0;
      @(negedge clk);
      batch_valid = 1'b0;
    end
    if (nb == B) begin
      lat = 1;
      while (!hit_valid && lat < 20) begin @(negedge clk); lat++; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; batch_valid = 1'b0; hit_ready = 1'b0;
    batch_bus = '0;
    #12;
    n_checks++;
    if ({batch_ready, hit_valid, busy} !== 3'b000)
      $display("FAIL reset_ctrl got %b want 000", {batch_ready, hit_valid, busy});
    else n_pass++;
    n_checks++;
    if ({hit_index, hit_found} !== 6'd0)
      $display("FAIL reset_index got %0d/%0b want 0/0", hit_index, hit_found);
    else n_pass++;
    n_checks++;
    if (hit_dist !== MISS) $display("FAIL reset_dist got %0d want 1023", hit_dist);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_nearest();
    int lat; bit ok;
    load_scn1();
    feed_ray(B, 0, lat, ok);
    n_checks++;
    if (!ok || lat != LAT) $display("FAIL nearest_latency got %0d ok=%0b want %0d", lat, ok, LAT);
    else n_pass++;
    n_checks++;
    if ({hit_valid, hit_index, hit_dist, hit_found} !== {1'b1, 5'd10, 10'd100, 1'b1})
      $display("FAIL nearest_result got v=%0b idx=%0d d=%0d f=%0b want 1/10/100/1",
               hit_valid, hit_index, hit_dist, hit_found);
    else n_pass++;
    hit_ready = 1'b1; @(negedge clk); hit_ready = 1'b0;
    n_checks++;
    if ({hit_valid, busy} !== 2'b00) $display("FAIL nearest_release got %b want 00", {hit_valid, busy});
    else n_pass++;
  endtask

  task automatic test_all_miss();
    int lat; bit ok;
    fill(MISS);
    feed_ray(B, 1, lat, ok);
    n_checks++;
    if (!ok || !hit_valid || {hit_index, hit_dist, hit_found} !== {5'd0, MISS, 1'b0})
      $display("FAIL all_miss got v=%0b idx=%0d d=%0d f=%0b want 1/0/1023/0",
               hit_valid, hit_index, hit_dist, hit_found);
    else n_pass++;
    hit_ready = 1'b1; @(negedge clk); hit_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat; bit ok;
    load_scn1();
    feed_ray(B, 0, lat, ok);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      n_checks++;
      if ({hit_valid, batch_ready, hit_index, hit_dist, hit_found} !== {1'b1, 1'b0, 5'd10, 10'd100, 1'b1})
        $display("FAIL bp_hold cyc%0d got v=%0b r=%0b idx=%0d d=%0d want 1/0/10/100",
                 i, hit_valid, batch_ready, hit_index, hit_dist);
      else n_pass++;
      @(negedge clk);
    end
    start = 1'b0;
    hit_ready = 1'b1; @(negedge clk); hit_ready = 1'b0;
    n_checks++;
    if ({hit_valid, busy} !== 2'b00) $display("FAIL bp_release got %b want 00", {hit_valid, busy});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || hit_dist !== 10'd100)
      $display("FAIL bp_idle_hold got busy=%0b d=%0d want 0/100", busy, hit_dist);
    else n_pass++;
  endtask

  task automatic test_abort();
    int lat; bit ok;
    load_scn1();
    feed_ray(2, 0, lat, ok);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    n_checks++;
    if ({hit_valid, busy} !== 2'b00) $display("FAIL abort_idle got %b want 00", {hit_valid, busy});
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({hit_valid, busy} !== 2'b00) $display("FAIL abort_quiet got %b want 00", {hit_valid, busy});
    else n_pass++;
    feed_ray(B, 0, lat, ok);
    n_checks++;
    if (!ok || lat != LAT || {hit_index, hit_dist} !== {5'd10, 10'd100})
      $display("FAIL abort_recover got lat=%0d idx=%0d d=%0d want %0d/10/100", lat, hit_index, hit_dist, LAT);
    else n_pass++;
    hit_ready = 1'b1; @(negedge clk); hit_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    int lat; bit ok;
    fill(MISS);
    g_d[0][3] = 10'd50;
    g_d[0][6] = 10'd50;
    feed_ray(1, 0, lat, ok);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({batch_ready, busy, hit_valid} !== 3'b000 || hit_dist !== MISS)
      $display("FAIL async_reset got r=%0b busy=%0b v=%0b d=%0d want 0/0/0/1023",
               batch_ready, busy, hit_valid, hit_dist);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    feed_ray(B, 0, lat, ok);
    n_checks++;
    if (!ok || {hit_valid, hit_index, hit_dist, hit_found} !== {1'b1, 5'd3, 10'd50, 1'b1})
      $display("FAIL slot_tie got v=%0b idx=%0d d=%0d f=%0b want 1/3/50/1",
               hit_valid, hit_index, hit_dist, hit_found);
    else n_pass++;
    hit_ready = 1'b1; @(negedge clk); hit_ready = 1'b0;
  endtask

  task automatic test_random();
    int lat; bit ok;
    logic [BW+W-1:0] e_idx;
    logic [L-1:0]    e_d;
    for (int r = 0; r < 30; r++) begin
      for (int b = 0; b < B; b++)
        for (int k = 0; k < N; k++) begin
          logic [L-1:0] v;
          v = $urandom_range(60, 40);
          g_d[b][k] = ($urandom_range(3, 0) == 0 && (r % 8) != 7) ? v : MISS;
        end
      ref_nearest(e_idx, e_d);
      feed_ray(B, 2, lat, ok);
      n_checks++;
      if (!ok || lat != LAT) $display("FAIL rand_latency ray%0d got %0d want %0d", r, lat, LAT);
      else n_pass++;
      repeat ($urandom_range(3, 0)) @(negedge clk);
      n_checks++;
      if ({hit_valid, hit_index, hit_dist, hit_found} !== {1'b1, e_idx, e_d, (e_d != MISS)})
        $display("FAIL rand_result ray%0d got v=%0b idx=%0d d=%0d f=%0b want 1/%0d/%0d/%0b",
                 r, hit_valid, hit_index, hit_dist, hit_found, e_idx, e_d, (e_d != MISS));
      else n_pass++;
      hit_ready = 1'b1; @(negedge clk); hit_ready = 1'b0;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL rand_release ray%0d got busy=%0b want 0", r, busy);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_nearest();
    test_all_miss();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
